// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bundle of control inputs, ROM bus and IF/ID outputs
interface if_stage_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              halt_i;
    logic [ADDR_W-1:0] rom_pc_o;
    logic [INST_W-1:0] rom_inst_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_valid_o;
    logic              halted_o;
    logic [CNT_W-1:0]  fetch_cnt_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, halt_i, rom_inst_i,
        output rom_pc_o, id_pc_o, id_inst_o, id_valid_o, halted_o, fetch_cnt_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, halt_i, rom_inst_i,
        input  rom_pc_o, id_pc_o, id_inst_o, id_valid_o, halted_o, fetch_cnt_o
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: PC, ROM addressing and IF/ID register with stall, redirect-flush and sticky halt
module if_stage #(
    parameter int                ADDR_W = 8,
    parameter int                INST_W = 32,
    parameter logic [INST_W-1:0] NOP    = INST_W'(32'h0000_0013),
    parameter int                CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, id_pc_q;
    logic [INST_W-1:0] id_inst_q;
    logic              id_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run, kill, advance;

    assign run     = state_q == RUN;
    assign kill    = run && (bus.halt_i || bus.redirect_i);
    assign advance = run && !bus.halt_i && !bus.redirect_i && !bus.stall_i;

    assign bus.rom_pc_o    = pc_q;
    assign bus.id_pc_o     = id_pc_q;
    assign bus.id_inst_o   = id_inst_q;
    assign bus.id_valid_o  = id_valid_q;
    assign bus.halted_o    = state_q == HALT;
    assign bus.fetch_cnt_o = cnt_q;

    // state register; HALT is left only through reset
    always_ff @(posedge clk) begin
        state_q <= rst ? RUN : state_d;
    end

    // halt request in RUN latches HALT; HALT ignores every input
    always_comb begin
        state_d = state_q;
        if (run && bus.halt_i) state_d = HALT;
    end

    // PC and IF/ID update: halt flushes, redirect flushes and retargets, stall holds, else advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP;
            id_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else if (kill) begin
            pc_q       <= bus.halt_i ? pc_q : bus.redirect_pc_i;
            id_inst_q  <= NOP;
            id_valid_q <= 1'b0;
        end else if (advance) begin
            pc_q       <= pc_q + 1'b1;
            id_pc_q    <= pc_q;
            id_inst_q  <= bus.rom_inst_i;
            id_valid_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
        end
    end
endmodule
